// File: rtl/morse_encoder.sv
// morse_encoder
//   Transmit-side Morse keyer. Accepts one 6-bit symbol code per valid/ready
//   handshake and plays it out as a timed key waveform (dot = 1 unit,
//   dash = 3 units, 1-unit element gap, 3-unit character gap). It also emits
//   one-cycle dot/dash strobes in the Morse decoder's input format, so it can
//   feed the decoder directly for loopback.
//
// Ports
//   Clock      : system clock, posedge
//   Reset      : synchronous, active-high
//   sym        : symbol code, 0-9 digits, 10-35 letters A..Z, 36-63 invalid
//   sym_valid  : sym is valid this cycle
//   sym_ready  : encoder can accept a symbol (IDLE only)
//   key        : keyed carrier, 1 = mark
//   dot        : strobe on the first cycle of each dot mark
//   dash       : strobe on the first cycle of each dash mark
//   busy       : high in every state except IDLE
//   err        : one-cycle pulse after an invalid code is accepted
module morse_encoder #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] sym,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       key,
    output logic       dot,
    output logic       dash,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] UNIT_LAST   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIPLE_LAST = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        CHAR_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [5:0]       r_sym;
    logic             r_ready;
    logic             r_key;
    logic             r_dot;
    logic             r_dash;
    logic             r_busy;
    logic             r_err;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [2:0]       w_next_idx;
    logic             w_xfer;
    logic [5:0]       w_code;
    logic [2:0]       w_len;
    logic [4:0]       w_pat;
    logic             w_cur_dash;
    logic [CNT_W-1:0] w_mark_last;
    logic             w_dot;
    logic             w_dash;
    logic             w_err;

    // {len[2:0], pat[4:0]}: first element in pat[4], 1 = dash; len 0 = invalid.
    function automatic logic [7:0] morse_lut(input logic [5:0] code);
        logic [7:0] v;
        case (code)
            6'd0:  v = {3'd5, 5'b11111};
            6'd1:  v = {3'd5, 5'b01111};
            6'd2:  v = {3'd5, 5'b00111};
            6'd3:  v = {3'd5, 5'b00011};
            6'd4:  v = {3'd5, 5'b00001};
            6'd5:  v = {3'd5, 5'b00000};
            6'd6:  v = {3'd5, 5'b10000};
            6'd7:  v = {3'd5, 5'b11000};
            6'd8:  v = {3'd5, 5'b11100};
            6'd9:  v = {3'd5, 5'b11110};
            6'd10: v = {3'd2, 5'b01000}; // A
            6'd11: v = {3'd4, 5'b10000}; // B
            6'd12: v = {3'd4, 5'b10100}; // C
            6'd13: v = {3'd3, 5'b10000}; // D
            6'd14: v = {3'd1, 5'b00000}; // E
            6'd15: v = {3'd4, 5'b00100}; // F
            6'd16: v = {3'd3, 5'b11000}; // G
            6'd17: v = {3'd4, 5'b00000}; // H
            6'd18: v = {3'd2, 5'b00000}; // I
            6'd19: v = {3'd4, 5'b01110}; // J
            6'd20: v = {3'd3, 5'b10100}; // K
            6'd21: v = {3'd4, 5'b01000}; // L
            6'd22: v = {3'd2, 5'b11000}; // M
            6'd23: v = {3'd2, 5'b10000}; // N
            6'd24: v = {3'd3, 5'b11100}; // O
            6'd25: v = {3'd4, 5'b01100}; // P
            6'd26: v = {3'd4, 5'b11010}; // Q
            6'd27: v = {3'd3, 5'b01000}; // R
            6'd28: v = {3'd3, 5'b00000}; // S
            6'd29: v = {3'd1, 5'b10000}; // T
            6'd30: v = {3'd3, 5'b00100}; // U
            6'd31: v = {3'd4, 5'b00010}; // V
            6'd32: v = {3'd3, 5'b01100}; // W
            6'd33: v = {3'd4, 5'b10010}; // X
            6'd34: v = {3'd4, 5'b10110}; // Y
            6'd35: v = {3'd4, 5'b11000}; // Z
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign w_xfer = sym_valid & r_ready;

    // On the accepting edge the first element must already be known so its
    // strobe can be registered for cycle 1; afterwards the captured code is used.
    assign w_code = w_xfer ? sym : r_sym;
    assign {w_len, w_pat} = morse_lut(w_code);

    assign w_cur_dash  = w_pat[3'd4 - r_idx];
    assign w_mark_last = w_cur_dash ? TRIPLE_LAST : UNIT_LAST;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_idx   = r_idx;
        w_dot        = 1'b0;
        w_dash       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (w_len != 3'd0) begin
                        w_next_state = MARK;
                        w_next_cnt   = '0;
                        w_next_idx   = '0;
                        w_dash       = w_pat[4];
                        w_dot        = ~w_pat[4];
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            MARK: begin
                if (r_cnt == w_mark_last) begin
                    w_next_cnt = '0;
                    if (r_idx == w_len - 3'd1) begin
                        w_next_state = CHAR_GAP;
                    end else begin
                        w_next_state = GAP;
                    end
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == UNIT_LAST) begin
                    w_next_state = MARK;
                    w_next_cnt   = '0;
                    w_next_idx   = r_idx + 3'd1;
                    // Strobe reflects the element about to start (index + 1).
                    w_dash       = w_pat[3'd3 - r_idx];
                    w_dot        = ~w_pat[3'd3 - r_idx];
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            CHAR_GAP: begin
                if (r_cnt == TRIPLE_LAST) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                    w_next_idx   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
                w_next_idx   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sym   <= '0;
            r_ready <= 1'b0;
            r_key   <= 1'b0;
            r_dot   <= 1'b0;
            r_dash  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_idx   <= w_next_idx;
            if (w_xfer) begin
                r_sym <= sym;
            end
            r_ready <= (w_next_state == IDLE);
            r_key   <= (w_next_state == MARK);
            r_busy  <= (w_next_state != IDLE);
            r_dot   <= w_dot;
            r_dash  <= w_dash;
            r_err   <= w_err;
        end
    end

    assign sym_ready = r_ready;
    assign key       = r_key;
    assign dot       = r_dot;
    assign dash      = r_dash;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Testbench for morse_encoder. Two instances (UNIT_CYCLES 4 and 1) share the
// input stimulus; "mon" selects which one the tasks observe. Expected
// waveforms are built from the Morse strings of each code.
module tb_morse_encoder;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [5:0] sym;
    logic       sym_valid;

    logic ready4, key4, dot4, dash4, busy4, err4;
    logic ready1, key1, dot1, dash1, busy1, err1;

    int mon = 0;
    logic m_ready, m_key, m_dot, m_dash, m_busy, m_err;
    assign m_ready = (mon == 1) ? ready1 : ready4;
    assign m_key   = (mon == 1) ? key1   : key4;
    assign m_dot   = (mon == 1) ? dot1   : dot4;
    assign m_dash  = (mon == 1) ? dash1  : dash4;
    assign m_busy  = (mon == 1) ? busy1  : busy4;
    assign m_err   = (mon == 1) ? err1   : err4;

    int checks = 0;
    int errors = 0;

    bit exp_key[$];
    bit exp_dot[$];
    bit exp_dash[$];

    string MORSE [36] = '{
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----.",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    morse_encoder #(.UNIT_CYCLES(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .sym(sym), .sym_valid(sym_valid),
        .sym_ready(ready4), .key(key4), .dot(dot4), .dash(dash4),
        .busy(busy4), .err(err4)
    );

    morse_encoder #(.UNIT_CYCLES(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .sym(sym), .sym_valid(sym_valid),
        .sym_ready(ready1), .key(key1), .dot(dot1), .dash(dash1),
        .busy(busy1), .err(err1)
    );

    always #5 Clock = ~Clock;

    function automatic int decode(input string s);
        for (int i = 0; i < 36; i++) begin
            if (MORSE[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic push_space(input int n);
        for (int i = 0; i < n; i++) begin
            exp_key.push_back(1'b0);
            exp_dot.push_back(1'b0);
            exp_dash.push_back(1'b0);
        end
    endtask

    // Per-cycle expectation for one symbol, starting with cycle 1 after accept.
    task automatic build_wave(input string s, input int unit);
        exp_key.delete();
        exp_dot.delete();
        exp_dash.delete();
        for (int e = 0; e < s.len(); e++) begin
            bit is_dash;
            int d;
            is_dash = (s[e] == "-");
            d = is_dash ? 3 * unit : unit;
            for (int c = 0; c < d; c++) begin
                exp_key.push_back(1'b1);
                exp_dot.push_back((c == 0) && !is_dash);
                exp_dash.push_back((c == 0) && is_dash);
            end
            if (e != s.len() - 1) push_space(unit);
        end
        push_space(3 * unit);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge Clock);
        end
    endtask

    // Sends one code on the monitored instance and checks its whole waveform.
    task automatic send_and_check(input int code, input int unit, input string tag,
                                  output int busy_cycles, output string got);
        bit ok;
        int n, key_bad, strb_bad, busy_bad;
        bit end_ready, end_busy;
        busy_cycles = 0;
        got = "";
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s ready-timeout: sym_ready=0 after 400 cycles, required 1", tag);
            return;
        end
        sym       = code[5:0];
        sym_valid = 1'b1;
        build_wave(MORSE[code], unit);
        n = exp_key.size();
        key_bad = 0; strb_bad = 0; busy_bad = 0;
        end_ready = 1'b0; end_busy = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                sym_valid = 1'b0;
                sym = 6'($urandom);
            end
            if (m_busy === 1'b1) busy_cycles++;
            if (k <= n) begin
                if (m_key !== exp_key[k-1]) key_bad++;
                if (m_dot !== exp_dot[k-1] || m_dash !== exp_dash[k-1] || m_err !== 1'b0) strb_bad++;
                if (m_busy !== 1'b1 || m_ready !== 1'b0) busy_bad++;
            end else begin
                end_ready = m_ready;
                end_busy  = m_busy;
            end
            if (m_dot === 1'b1 && m_dash === 1'b1) got = {got, "*"};
            else if (m_dot === 1'b1) got = {got, "."};
            else if (m_dash === 1'b1) got = {got, "-"};
        end
        checks++;
        if (key_bad != 0) begin
            errors++;
            $display("FAIL %s key-wave: %0d bad cycles, required 0", tag, key_bad);
        end
        checks++;
        if (strb_bad != 0) begin
            errors++;
            $display("FAIL %s strobe-wave: %0d bad cycles, required 0", tag, strb_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy/ready-wave: %0d bad cycles, required 0", tag, busy_bad);
        end
        checks++;
        if (end_ready !== 1'b1 || end_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s ready-after: ready=%0b busy=%0b, required ready=1 busy=0",
                     tag, end_ready, end_busy);
        end
        checks++;
        if (decode(got) != code) begin
            errors++;
            $display("FAIL %s loopback: strobes '%s' decode to %0d, required %0d",
                     tag, got, decode(got), code);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({ready4, key4, dot4, dash4, busy4, err4, ready1, key1, dot1, dash1, busy1, err1} !== 12'h000) begin
            errors++;
            $display("FAIL reset-outputs: got %b, required all 0",
                     {ready4, key4, dot4, dash4, busy4, err4, ready1, key1, dot1, dash1, busy1, err1});
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if ({ready4, busy4, ready1, busy1} !== 4'b1010) begin
            errors++;
            $display("FAIL reset-release: ready4/busy4/ready1/busy1=%b, required 1010",
                     {ready4, busy4, ready1, busy1});
        end
    endtask

    task automatic test_letter_e;
        int b;
        string g;
        mon = 0;
        send_and_check(14, 4, "E", b, g);
        checks++;
        if (b != 16) begin
            errors++;
            $display("FAIL E busy-cycles: got %0d, required 16", b);
        end
        checks++;
        if (g != ".") begin
            errors++;
            $display("FAIL E strobes: got '%s', required '.'", g);
        end
    endtask

    task automatic test_digit_zero;
        int b;
        string g;
        mon = 0;
        send_and_check(0, 4, "digit0", b, g);
        checks++;
        if (b != 88) begin
            errors++;
            $display("FAIL digit0 busy-cycles: got %0d, required 88", b);
        end
        checks++;
        if (g != "-----") begin
            errors++;
            $display("FAIL digit0 strobes: got '%s', required '-----'", g);
        end
    endtask

    task automatic test_all_codes;
        int order[36];
        int b;
        string g;
        mon = 0;
        for (int i = 0; i < 36; i++) order[i] = i;
        for (int i = 35; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 36; i++) begin
            send_and_check(order[i], 4, $sformatf("code%0d", order[i]), b, g);
        end
    endtask

    task automatic test_invalid;
        int codes[3];
        bit ok;
        mon = 0;
        codes[0] = 36;
        codes[1] = 63;
        codes[2] = int'($urandom_range(62, 37));
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL invalid ready-timeout: sym_ready=0, required 1");
            return;
        end
        for (int i = 0; i < 3; i++) begin
            sym = codes[i][5:0];
            sym_valid = 1'b1;
            @(negedge Clock);
            sym_valid = 1'b0;
            checks++;
            if ({m_err, m_key, m_dot, m_dash, m_ready, m_busy} !== 6'b100010) begin
                errors++;
                $display("FAIL invalid%0d err-cycle: err/key/dot/dash/ready/busy=%b, required 100010",
                         codes[i], {m_err, m_key, m_dot, m_dash, m_ready, m_busy});
            end
            @(negedge Clock);
            checks++;
            if ({m_err, m_key, m_dot, m_dash, m_ready} !== 5'b00001) begin
                errors++;
                $display("FAIL invalid%0d after: err/key/dot/dash/ready=%b, required 00001",
                         codes[i], {m_err, m_key, m_dot, m_dash, m_ready});
            end
        end
        // Second invalid transfer lands in the err cycle of the first.
        sym = 6'd36;
        sym_valid = 1'b1;
        @(negedge Clock);
        checks++;
        if ({m_err, m_ready} !== 2'b11) begin
            errors++;
            $display("FAIL invalid-b2b first: err/ready=%b, required 11", {m_err, m_ready});
        end
        sym = 6'd63;
        @(negedge Clock);
        sym_valid = 1'b0;
        checks++;
        if ({m_err, m_ready, m_key} !== 3'b110) begin
            errors++;
            $display("FAIL invalid-b2b second: err/ready/key=%b, required 110", {m_err, m_ready, m_key});
        end
        @(negedge Clock);
        checks++;
        if ({m_err, m_busy} !== 2'b00) begin
            errors++;
            $display("FAIL invalid-b2b end: err/busy=%b, required 00", {m_err, m_busy});
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int b;
        string g;
        mon = 0;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset-mid ready-timeout: sym_ready=0, required 1");
            return;
        end
        sym = 6'd29;
        sym_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clock);
            if (k == 1) sym_valid = 1'b0;
        end
        checks++;
        if (m_key !== 1'b1) begin
            errors++;
            $display("FAIL reset-mid pre: key=%0b on dash cycle 6, required 1", m_key);
        end
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({m_key, m_ready, m_busy, m_dash} !== 4'b0000) begin
            errors++;
            $display("FAIL reset-mid during: key/ready/busy/dash=%b, required 0000",
                     {m_key, m_ready, m_busy, m_dash});
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if ({m_ready, m_key, m_busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset-mid release: ready/key/busy=%b, required 100", {m_ready, m_key, m_busy});
        end
        send_and_check(14, 4, "E-after-reset", b, g);
        checks++;
        if (b != 16 || g != ".") begin
            errors++;
            $display("FAIL E-after-reset: busy=%0d strobes='%s', required 16 '.'", b, g);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit q_key[$], q_dot[$], q_dash[$], q_rdy[$];
        int n, e_len, bad_key, bad_strb, bad_rdy;
        bit fin_ready;
        mon = 1;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b ready-timeout: sym_ready=0, required 1");
            return;
        end
        build_wave(MORSE[14], 1);
        e_len = exp_key.size();
        for (int i = 0; i < e_len; i++) begin
            q_key.push_back(exp_key[i]); q_dot.push_back(exp_dot[i]);
            q_dash.push_back(exp_dash[i]); q_rdy.push_back(1'b0);
        end
        // Handoff cycle: idle for one cycle with ready high, T accepted here.
        q_key.push_back(1'b0); q_dot.push_back(1'b0); q_dash.push_back(1'b0); q_rdy.push_back(1'b1);
        build_wave(MORSE[29], 1);
        for (int i = 0; i < exp_key.size(); i++) begin
            q_key.push_back(exp_key[i]); q_dot.push_back(exp_dot[i]);
            q_dash.push_back(exp_dash[i]); q_rdy.push_back(1'b0);
        end
        n = q_key.size();
        bad_key = 0; bad_strb = 0; bad_rdy = 0; fin_ready = 1'b0;
        sym = 6'd14;
        sym_valid = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge Clock);
            if (k == 1) sym = 6'd29;
            if (k == e_len + 2) begin
                sym_valid = 1'b0;
                sym = 6'($urandom);
            end
            if (k <= n) begin
                if (m_key !== q_key[k-1]) bad_key++;
                if (m_dot !== q_dot[k-1] || m_dash !== q_dash[k-1]) bad_strb++;
                if (m_ready !== q_rdy[k-1]) bad_rdy++;
            end else begin
                fin_ready = m_ready;
            end
        end
        checks++;
        if (bad_key != 0) begin
            errors++;
            $display("FAIL b2b key-wave: %0d bad cycles, required 0", bad_key);
        end
        checks++;
        if (bad_strb != 0) begin
            errors++;
            $display("FAIL b2b strobe-wave: %0d bad cycles, required 0", bad_strb);
        end
        checks++;
        if (bad_rdy != 0 || fin_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b ready-wave: %0d bad cycles, final ready=%0b, required 0 and 1",
                     bad_rdy, fin_ready);
        end
    endtask

    initial begin
        Reset = 1'b1;
        sym = '0;
        sym_valid = 1'b0;
        repeat (3) @(negedge Clock);
        test_reset;
        test_letter_e;
        test_digit_zero;
        test_all_codes;
        test_invalid;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
